// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 datapath types and condition-code helper
package lc3_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [IDX_W-1:0]  reg_idx_t;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;

  localparam logic [2:0] CC_Z = 3'b010;

  // Exactly one of N/Z/P is ever set for any input value.
  function automatic nzp_t cc_of(input data_t d);
    nzp_t cc;
    cc.n = d[DATA_W-1];
    cc.z = (d == '0);
    cc.p = !cc.n && !cc.z;
    return cc;
  endfunction

endpackage

// File: rtl/lc3_cc_gen.sv
// rtl/lc3_cc_gen.sv - combinational NZP generator, shared with the branch unit
module lc3_cc_gen
  import lc3_pkg::*;
(
  input  data_t data,
  output nzp_t  nzp
);

  assign nzp = cc_of(data);

endmodule

// File: rtl/lc3_regfile_cc.sv
// rtl/lc3_regfile_cc.sv - LC-3 R0-R7 register file with NZP condition codes
module lc3_regfile_cc
  import lc3_pkg::*;
#(
  parameter int         DATA_W   = 16,
  parameter int         NUM_REGS = 8,
  parameter logic [2:0] CC_RESET = CC_Z
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_reg,
  input  logic [$clog2(NUM_REGS)-1:0] dr,
  input  logic [$clog2(NUM_REGS)-1:0] sr1,
  input  logic [$clog2(NUM_REGS)-1:0] sr2,
  input  logic [DATA_W-1:0]           bus_in,
  input  logic                        ld_cc,
  output logic [DATA_W-1:0]           ra,
  output logic [DATA_W-1:0]           rb,
  output logic [2:0]                  nzp,
  output logic                        cc_valid
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [2:0]        nzp_q;
  logic              cc_valid_q;
  nzp_t              cc_next;

  lc3_cc_gen u_cc_gen (
    .data (bus_in),
    .nzp  (cc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (ld_reg) begin
      regs[dr] <= bus_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzp_q      <= CC_RESET;
      cc_valid_q <= 1'b0;
    end else if (ld_cc) begin
      nzp_q      <= cc_next;
      cc_valid_q <= 1'b1;
    end
  end

  // No write bypass: bus_in is derived from ra/rb through the ALU.
  assign ra       = regs[sr1];
  assign rb       = regs[sr2];
  assign nzp      = nzp_q;
  assign cc_valid = cc_valid_q;

endmodule

// File: tb/tb_lc3_regfile_cc.sv
// tb/tb_lc3_regfile_cc.sv - directed table-driven bench for lc3_regfile_cc
module tb_lc3_regfile_cc;

  logic        clk;
  logic        rst;
  logic        ld_reg;
  logic [2:0]  dr;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] bus_in;
  logic        ld_cc;
  logic [15:0] ra;
  logic [15:0] rb;
  logic [2:0]  nzp;
  logic        cc_valid;

  int n_checks = 0;
  int n_fail   = 0;

  lc3_regfile_cc dut (
    .clk      (clk),
    .rst      (rst),
    .ld_reg   (ld_reg),
    .dr       (dr),
    .sr1      (sr1),
    .sr2      (sr2),
    .bus_in   (bus_in),
    .ld_cc    (ld_cc),
    .ra       (ra),
    .rb       (rb),
    .nzp      (nzp),
    .cc_valid (cc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld_reg;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] bus_in;
    logic        ld_cc;
    logic [15:0] exp_ra;
    logic [15:0] exp_rb;
    logic [2:0]  exp_nzp;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [15:0] e_ra, input logic [15:0] e_rb,
                           input logic [2:0] e_nzp, input logic e_valid);
    chk({tag, " ra"}, ra, e_ra);
    chk({tag, " rb"}, rb, e_rb);
    chk({tag, " nzp"}, {13'd0, nzp}, {13'd0, e_nzp});
    chk({tag, " cc_valid"}, {15'd0, cc_valid}, {15'd0, e_valid});
  endtask

  task automatic add_vec(input logic l_reg, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [15:0] b, input logic l_cc,
                         input logic [15:0] e_ra, input logic [15:0] e_rb,
                         input logic [2:0] e_nzp, input logic e_valid);
    vec_t v;
    v.ld_reg = l_reg; v.dr = d; v.sr1 = s1; v.sr2 = s2; v.bus_in = b; v.ld_cc = l_cc;
    v.exp_ra = e_ra; v.exp_rb = e_rb; v.exp_nzp = e_nzp; v.exp_valid = e_valid;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic l_reg, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [15:0] b, input logic l_cc);
    ld_reg = l_reg; dr = d; sr1 = s1; sr2 = s2; bus_in = b; ld_cc = l_cc;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0);

    // Writes: each register read back on the edge it was written.
    for (int i = 0; i < 8; i++)
      add_vec(1'b1, 3'(i), 3'(i), 3'(i), 16'(16'h1111 * i), 1'b0,
              16'(16'h1111 * i), 16'(16'h1111 * i), 3'b010, 1'b0);
    // Reads with ld_reg=0 and garbage on the bus: contents must hold.
    for (int i = 0; i < 8; i++)
      add_vec(1'b0, 3'(i), 3'(i), 3'(7 - i), 16'hDEAD, 1'b0,
              16'(16'h1111 * i), 16'(16'h1111 * (7 - i)), 3'b010, 1'b0);
    add_vec(1'b0, 3'd0, 3'd1, 3'd2, 16'h8000, 1'b1, 16'h1111, 16'h2222, 3'b100, 1'b1);
    add_vec(1'b0, 3'd0, 3'd1, 3'd2, 16'h0000, 1'b1, 16'h1111, 16'h2222, 3'b010, 1'b1);
    add_vec(1'b0, 3'd0, 3'd1, 3'd2, 16'h7FFF, 1'b1, 16'h1111, 16'h2222, 3'b001, 1'b1);
    add_vec(1'b0, 3'd0, 3'd1, 3'd2, 16'hFFFF, 1'b1, 16'h1111, 16'h2222, 3'b100, 1'b1);
    add_vec(1'b0, 3'd0, 3'd1, 3'd2, 16'h0000, 1'b0, 16'h1111, 16'h2222, 3'b100, 1'b1);
    add_vec(1'b1, 3'd5, 3'd5, 3'd4, 16'hFFFE, 1'b1, 16'hFFFE, 16'h4444, 3'b100, 1'b1);
    add_vec(1'b0, 3'd0, 3'd6, 3'd6, 16'h0001, 1'b0, 16'h6666, 16'h6666, 3'b100, 1'b1);

    repeat (2) @(posedge clk);
    #1 chk_state("reset", 16'h0000, 16'h0000, 3'b010, 1'b0);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].ld_reg, vecs[k].dr, vecs[k].sr1, vecs[k].sr2, vecs[k].bus_in, vecs[k].ld_cc);
      @(posedge clk);
      #1 chk_state($sformatf("vec%0d", k), vecs[k].exp_ra, vecs[k].exp_rb,
                   vecs[k].exp_nzp, vecs[k].exp_valid);
    end

    // Read-during-write returns the old value until the edge.
    @(negedge clk) drive(1'b1, 3'd3, 3'd0, 3'd0, 16'h00AA, 1'b0);
    @(negedge clk) drive(1'b1, 3'd3, 3'd3, 3'd3, 16'h5555, 1'b0);
    #1 chk("rdw before edge", ra, 16'h00AA);
    @(posedge clk);
    #1 chk("rdw after edge", ra, 16'h5555);

    // Asynchronous reset mid-cycle, no clock edge needed.
    @(negedge clk) drive(1'b0, 3'd0, 3'd7, 3'd5, 16'h0000, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      #0.1 chk_state($sformatf("async rst %0d", i), 16'h0000, 16'h0000, 3'b010, 1'b0);
    end
    @(negedge clk) rst = 1'b0;

    // Reset coincident with loads: nothing is written.
    @(negedge clk) drive(1'b1, 3'd2, 3'd2, 3'd2, 16'h4321, 1'b1);
    @(posedge clk);
    #1 chk_state("pre rst", 16'h4321, 16'h4321, 3'b001, 1'b1);
    @(negedge clk);
    drive(1'b1, 3'd2, 3'd2, 3'd2, 16'h1234, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 chk_state("rst over load", 16'h0000, 16'h0000, 3'b010, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk_state("post rst write", 16'h1234, 16'h1234, 3'b001, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_regfile_cc.md
Name: lc3_regfile_cc

Overview:
- Architectural register file (R0–R7, 16 bit each) plus NZP condition-code register for the multi-cycle LC-3 datapath.
- Sits directly upstream of the ALU: its two read ports drive the ALU Ra/Rb operands.
- Captures results from the internal bus (ALU output, memory data, PC) at the end of a control-FSM state.
- Sets N/Z/P from the same bus value when the control FSM asserts ld_cc.

Parameters:
- DATA_W, 16, data width; must match bit16 dataWidth.
- NUM_REGS, 8, number of general registers; index width is $clog2(NUM_REGS) = 3.
- CC_RESET, 3'b010, NZP value after reset (Z set).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- ld_reg  input  1  write enable for register dr
- dr  input  3  destination register index
- sr1  input  3  read port A index (drives ALU Ra)
- sr2  input  3  read port B index (drives ALU Rb)
- bus_in  input  16  write data and CC source
- ld_cc  input  1  load NZP from bus_in
- ra  output  16  contents of R[sr1]
- rb  output  16  contents of R[sr2]
- nzp  output  3  {N,Z,P} condition codes
- cc_valid  output  1  high once NZP has been loaded at least once since reset

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state:
  - R0–R7 = 16'h0000.
  - nzp = CC_RESET (3'b010).
  - cc_valid = 0.
  - ra and rb therefore read 0.
  - Reset asserted mid-operation overrides any pending ld_reg/ld_cc in that cycle; nothing is written.
- Write:
  - On rising clk with ld_reg=1, R[dr] <= bus_in.
  - Single write port; no write when ld_reg=0.
- Read:
  - ra/rb are purely combinational from the register array and sr1/sr2.
  - Zero-cycle latency.
  - No write-bypass: read-during-write to the same index returns the old value until the next edge.
  - Bypass is forbidden because bus_in is derived from ALUOut, and ALUOut is derived from ra/rb; a bypass would create a combinational loop.
  - sr1 == sr2 is legal; both ports return the same value.
- Condition codes:
  - On rising clk with ld_cc=1, nzp is loaded from bus_in:
    - N = bus_in[15]
    - Z = (bus_in == 0)
    - P = !N && !Z
  - Exactly one bit of nzp is set at all times.
  - cc_valid <= 1 on the first ld_cc edge and stays 1 until reset.
- Simultaneous ld_reg and ld_cc:
  - Both update on the same edge from the same bus_in.
  - No ordering dependency.
- No R0-hardwired-zero behaviour: all eight registers are writable (LC-3 semantics).
- Indices are 3 bits, so out-of-range is impossible; no wrap logic is needed.
- No X propagation from reset: every flop has an explicit reset value.

Decomposition:
- Package lc3_pkg (extends the bit16 definitions):
  - data_t (16-bit logic)
  - reg_idx_t (3-bit logic)
  - nzp_t (packed struct {n,z,p})
  - constant CC_Z = 3'b010
  - function cc_of(data_t) returning nzp_t
- Sub-module lc3_cc_gen:
  - Combinational; data_t in, nzp_t out.
  - Reused by the branch unit (BR compares IR[11:9] against nzp).
- lc3_regfile_cc instantiates lc3_cc_gen and owns the CC flop and the register array.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle; sweep sr1/sr2 over 0–7 → ra=rb=16'h0000, nzp=3'b010, cc_valid=0, changing immediately without waiting for clk.
2. Write/read all registers: write R[i]=16'h1111*i for i=0..7 with ld_reg=1, then read with sr1=i, sr2=7-i → ra=16'h1111*i, rb=16'h1111*(7-i); ld_reg=0 cycles leave contents unchanged.
3. Read-during-write: R3=16'h00AA; in the same cycle set dr=3, sr1=3, bus_in=16'h5555, ld_reg=1 → ra=16'h00AA before the edge, 16'h5555 after it.
4. Condition codes, each with ld_cc=1:
   - bus_in=16'h8000 → nzp=100
   - bus_in=16'h0000 → nzp=010
   - bus_in=16'h7FFF → nzp=001
   - bus_in=16'hFFFF → nzp=100
   - cc_valid rises after the first load.
   - A following cycle with ld_cc=0 and bus_in=0 leaves nzp unchanged.
5. Simultaneous load: dr=5, bus_in=16'hFFFE, ld_reg=1, ld_cc=1 → R5=16'hFFFE and nzp=100 on the same edge.
6. Reset mid-operation: assert rst coincident with ld_reg=1 (dr=2, bus_in=16'h1234) and ld_cc=1 → R2=0, nzp=010, cc_valid=0 after release; a normal write on the first edge after deassertion succeeds.
